// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - 8N1 UART receiver with 16x oversampling and built-in baud tick divider
// Delivers one byte per good frame as a one-clk write strobe; frames with a bad stop bit are dropped.
module uart_rx_frontend #(
  parameter int DBIT      = 8,
  parameter int SB_TICK   = 16,
  parameter int BAUD_DVSR = 163,
  parameter int DVSR_W    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_rx_meta;
  logic              r_rx_s;
  logic [DVSR_W-1:0] r_dvsr_cnt;
  logic              w_s_tick;
  logic [3:0]        r_s_cnt;
  logic [3:0]        w_s_cnt_next;
  logic [2:0]        r_n_cnt;
  logic [2:0]        w_n_cnt_next;
  logic [DBIT-1:0]   r_b_reg;
  logic [DBIT-1:0]   w_b_next;
  logic [DBIT-1:0]   r_rx_data;
  logic [DBIT-1:0]   w_data_next;
  logic              r_done;
  logic              w_done_next;
  logic              r_ferr;
  logic              w_ferr_next;

  assign w_s_tick = (r_dvsr_cnt == DVSR_W'(BAUD_DVSR - 1));

  // Synchronizer flops reset to 1 so a reset release on an idle line never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_dvsr_cnt <= '0;
    end else begin
      r_rx_meta  <= rx;
      r_rx_s     <= r_rx_meta;
      r_dvsr_cnt <= w_s_tick ? '0 : r_dvsr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_s_cnt   <= '0;
      r_n_cnt   <= '0;
      r_b_reg   <= '0;
      r_rx_data <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_s_cnt   <= w_s_cnt_next;
      r_n_cnt   <= w_n_cnt_next;
      r_b_reg   <= w_b_next;
      r_rx_data <= w_data_next;
      r_done    <= w_done_next;
      r_ferr    <= w_ferr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_cnt_next = r_s_cnt;
    w_n_cnt_next = r_n_cnt;
    w_b_next     = r_b_reg;
    w_data_next  = r_rx_data;
    w_done_next  = 1'b0;
    w_ferr_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_next = S_START;
          w_s_cnt_next = '0;
        end
      end
      S_START: begin
        if (w_s_tick) begin
          if (r_s_cnt == 4'd7) begin
            if (!r_rx_s) begin
              w_state_next = S_DATA;
              w_s_cnt_next = '0;
              w_n_cnt_next = '0;
            end else begin
              w_state_next = S_IDLE;
            end
          end else begin
            w_s_cnt_next = r_s_cnt + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (w_s_tick) begin
          if (r_s_cnt == 4'd15) begin
            w_b_next     = {r_rx_s, r_b_reg[DBIT-1:1]};
            w_s_cnt_next = '0;
            if (r_n_cnt == 3'(DBIT - 1)) begin
              w_state_next = S_STOP;
            end else begin
              w_n_cnt_next = r_n_cnt + 3'd1;
            end
          end else begin
            w_s_cnt_next = r_s_cnt + 4'd1;
          end
        end
      end
      S_STOP: begin
        // Leaving mid stop bit leaves half a bit of margin to catch a back-to-back start edge.
        if (w_s_tick) begin
          if (r_s_cnt == 4'(SB_TICK - 1)) begin
            w_state_next = S_IDLE;
            if (r_rx_s) begin
              w_data_next = r_b_reg;
              w_done_next = 1'b1;
            end else begin
              w_ferr_next = 1'b1;
            end
          end else begin
            w_s_cnt_next = r_s_cnt + 4'd1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign rx_data      = r_rx_data;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb/tb_uart_rx_frontend.sv - directed self-checking bench for uart_rx_frontend (64 clk per bit)
module tb_uart_rx_frontend;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         busy_cnt = 0;
  int         both_viol = 0;
  int         long_viol = 0;
  logic       prev_done = 1'b0;
  logic       prev_ferr = 1'b0;
  logic [7:0] fifo_q[$];

  uart_rx_frontend #(
    .DBIT(8),
    .SB_TICK(16),
    .BAUD_DVSR(4),
    .DVSR_W(8)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .rx(rx),
    .rx_data(rx_data),
    .rx_done_tick(rx_done_tick),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Downstream FIFO model: every rx_done_tick writes rx_data.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_done_tick) begin
        done_cnt++;
        fifo_q.push_back(rx_data);
      end
      if (frame_err) ferr_cnt++;
      if (busy) busy_cnt++;
      if (rx_done_tick && frame_err) both_viol++;
      if ((rx_done_tick && prev_done) || (frame_err && prev_ferr)) long_viol++;
    end
    prev_done = rx_done_tick;
    prev_ferr = frame_err;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_len);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop_val;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%0h exp=00", rx_data); end
    checks++; if (rx_done_tick !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", rx_done_tick); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%0b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    rst_n = 1'b1;
    idle(20);
  endtask

  task automatic test_good_byte;
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'hA5, 1'b1, BIT_CLKS);
    idle(40);
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL good_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL good_rx_data got=%0h exp=a5", rx_data); end
    checks++; if (ferr_cnt != f0) begin failures++; $display("FAIL good_ferr_count got=%0d exp=0", ferr_cnt - f0); end
  endtask

  task automatic test_glitch;
    int d0, f0, b0;
    d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    idle(100);
    checks++; if (busy_cnt == b0) begin failures++; $display("FAIL glitch_busy_pulse got=0 cycles exp=>0"); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_end got=%0b exp=0", busy); end
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL glitch_done got=%0d exp=0", done_cnt - d0); end
    checks++; if (ferr_cnt != f0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0); end
  endtask

  task automatic test_frame_err;
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    // Low stop bit held past its mid-bit sample point only, so the line is clearly idle afterwards.
    send_byte(8'h3C, 1'b0, 40);
    idle(150);
    checks++; if (ferr_cnt - f0 != 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL ferr_done got=%0d exp=0", done_cnt - d0); end
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL ferr_rx_data_hold got=%0h exp=a5", rx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_busy_end got=%0b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    int d0, f0, q0;
    logic [7:0] exp_bytes [3];
    exp_bytes[0] = 8'h0A; exp_bytes[1] = 8'h0B; exp_bytes[2] = 8'h0C;
    d0 = done_cnt; f0 = ferr_cnt; q0 = fifo_q.size();
    for (int k = 0; k < 3; k++) send_byte(exp_bytes[k], 1'b1, BIT_CLKS);
    idle(40);
    checks++; if (done_cnt - d0 != 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", done_cnt - d0); end
    checks++; if (ferr_cnt != f0) begin failures++; $display("FAIL b2b_ferr got=%0d exp=0", ferr_cnt - f0); end
    checks++; if (rx_data !== 8'h0C) begin failures++; $display("FAIL b2b_last_rx_data got=%0h exp=0c", rx_data); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (fifo_q.size() <= q0 + k) begin
        failures++; $display("FAIL b2b_fifo_read%0d got=empty exp=%0h", k, exp_bytes[k]);
      end else if (fifo_q[q0 + k] !== exp_bytes[k]) begin
        failures++; $display("FAIL b2b_fifo_read%0d got=%0h exp=%0h", k, fifo_q[q0 + k], exp_bytes[k]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int d0, f0;
    logic [7:0] b;
    b = 8'hC3;
    d0 = done_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = b[3];
    repeat (BIT_CLKS / 2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%0b exp=1", busy); end
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy_in_reset got=%0b exp=0", busy); end
    rst_n = 1'b1;
    idle(200);
    checks++; if (done_cnt != d0 || ferr_cnt != f0) begin failures++; $display("FAIL midrst_no_pulse got=%0d/%0d exp=0/0", done_cnt - d0, ferr_cnt - f0); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL midrst_rx_data_cleared got=%0h exp=00", rx_data); end
    send_byte(8'h55, 1'b1, BIT_CLKS);
    idle(40);
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL midrst_after_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL midrst_after_rx_data got=%0h exp=55", rx_data); end
  endtask

  task automatic test_pulse_rules;
    checks++; if (both_viol != 0) begin failures++; $display("FAIL pulse_exclusive got=%0d exp=0", both_viol); end
    checks++; if (long_viol != 0) begin failures++; $display("FAIL pulse_single_clk got=%0d exp=0", long_viol); end
  endtask

  initial begin
    test_reset;
    test_good_byte;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_reset_mid_frame;
    test_pulse_rules;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
